sort_seq: RTL and testbench
===========================

SORT_SEQ -- requirements
Module: sort_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter DATA_W SHALL default to 9 and set the data word width.
REQ-003 Parameter DEPTH SHALL default to 6 and set words per block; legal range is 2..64.
REQ-004 Ports SHALL be, in order:
- clk  in  1  clock
- rst_n  in  1  sync active-low reset
- in_valid  in  1  data_in valid
- in_ready  out  1  block accepts data_in
- mode  in  2  00 pass, 01 descending, 10 ascending, 11 pass
- data_in  in  DATA_W  input word
- out_valid  out  1  data_out valid
- out_ready  in  1  consumer accepts data_out
- data_out  out  DATA_W  output word
- out_index  out  clog2(DEPTH)  position of data_out in block
- busy  out  1  high in any state other than IDLE

Function
REQ-005 The FSM SHALL have states IDLE, LOAD, SORT and OUT.
REQ-006 An input word SHALL be accepted on a cycle with in_valid && in_ready, and in_ready SHALL be 1 only in IDLE and LOAD.
REQ-007 The first accepted word SHALL latch mode for the whole block; mode changes later in the block SHALL be ignored.
REQ-008 Accepted words SHALL be stored at buffer index 0..DEPTH-1 in arrival order; gaps in in_valid SHALL stall loading without error.
REQ-009 IDLE SHALL go to LOAD on the first accept, and LOAD SHALL exit on the cycle after the DEPTH-th accept.
REQ-010 On LOAD exit the FSM SHALL go to SORT for modes 01/10 and to OUT for modes 00/11.
REQ-011 SORT SHALL run odd-even transposition: exactly DEPTH cycles, one compare-exchange pass per cycle, starting with the even-pair phase and alternating.
REQ-012 Compare-exchange SHALL be unsigned and SHALL swap only on strict inequality, so equal values keep arrival order (stable sort).
REQ-013 Descending mode SHALL place the largest value at index 0; ascending mode SHALL place the smallest value at index 0.
REQ-014 The FSM SHALL enter OUT after the DEPTH-th SORT cycle, with no early termination.
REQ-015 Latency from the cycle of the last accept to the first out_valid SHALL be 1 cycle in pass mode and DEPTH+1 cycles in sort mode.
REQ-016 In OUT, out_valid SHALL be 1, data_out SHALL equal buf[out_index], and out_index SHALL start at 0.
REQ-017 out_index SHALL increment on out_valid && out_ready; data_out and out_index SHALL hold stable while out_ready is 0.
REQ-018 A transfer at out_index == DEPTH-1 SHALL return the FSM to IDLE on the next cycle, and in_ready SHALL be 1 on that cycle.
REQ-019 data_out SHALL be 0 whenever out_valid is 0.
REQ-020 Words offered while in_ready is 0 SHALL be ignored and SHALL not be stored.

Reset
REQ-021 With rst_n low at a clk edge, the block SHALL set state IDLE, out_valid 0, data_out 0, out_index 0, busy 0, in_ready 1, and clear the load counter and SORT pass counter.
REQ-022 Buffer contents SHALL not be reset, and no stale buffer content SHALL be visible at the outputs.
REQ-023 Reset in any state, including mid-SORT or mid-OUT, SHALL abort the block; the next block SHALL behave as if starting from power-up.

Structure
REQ-024 Package sort_pkg SHALL hold:
- the FSM state encoding
- mode encodings MODE_PASS=00, MODE_DESC=01, MODE_ASC=10
- a count-width function
REQ-025 Sub-module sort_cmp_swap, parametrised by DATA_W, SHALL implement one compare-exchange pair: inputs a, b and dir; outputs lo_pos and hi_pos. sort_seq SHALL instantiate floor(DEPTH/2) of them, with pair alignment selected by phase.
REQ-026 All state SHALL be in one clock domain, and the target RTL size SHALL be 120..400 lines.

Verification (DEPTH=6, DATA_W=9)
REQ-027 Pass mode: mode 00, input 5,300,0,511,7,7 with continuous in_valid and out_ready=1 -> output 5,300,0,511,7,7 at out_index 0..5; out_valid first high 1 cycle after the last accept.
REQ-028 Descending: mode 01, input 3,9,1,9,0,4 -> output 9,9,4,3,1,0; first out_valid 7 cycles after the last accept; busy high throughout.
REQ-029 Ascending with stall: mode 10, input 511,0,256,0,1,2, out_ready low for 3 cycles at out_index 1 -> data_out holds 0 and out_index holds 1; full output 0,0,1,2,256,511.
REQ-030 Load gaps and stray words: in_valid low for 2 cycles between words 3 and 4 -> correct block; a word offered during SORT/OUT (in_ready=0) is absent from output; mode toggled mid-load has no effect.
REQ-031 Reset mid-SORT (third pass) -> next cycle out_valid=0, data_out=0, in_ready=1, busy=0; a following block 6,5,4,3,2,1 in mode 10 outputs 1..6.
REQ-032 Back-to-back blocks: a new in_valid word presented on the cycle after the final output transfer is accepted immediately; mode 11 outputs in arrival order.

Source files
------------

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared FSM states, mode encodings and counter sizing for sort_seq
package sort_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_SORT = 2'b10,
      ST_OUT  = 2'b11
   } state_t;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_DESC = 2'b01;
   localparam logic [1:0] MODE_ASC  = 2'b10;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// rtl/sort_cmp_swap.sv - one stable compare-exchange pair (dir=1 puts the larger value at lo_pos)
module sort_cmp_swap
   import sort_pkg::*;
#(
   parameter int DATA_W = 9
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              dir,
   output logic [DATA_W-1:0] lo_pos,
   output logic [DATA_W-1:0] hi_pos
);

   logic swap;

   always_comb begin
      // Strict compares only, so equal words never trade places.
      swap   = dir ? (a < b) : (a > b);
      lo_pos = swap ? b : a;
      hi_pos = swap ? a : b;
   end

endmodule

// File: rtl/sort_seq.sv
// rtl/sort_seq.sv - block loader with odd-even transposition sort and indexed readout
module sort_seq
   import sort_pkg::*;
#(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               mode,
   input  logic [DATA_W-1:0]        data_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        data_out,
   output logic [$clog2(DEPTH)-1:0] out_index,
   output logic                     busy
);

   localparam int CNT_W = cnt_width(DEPTH);
   localparam int NPAIR = DEPTH / 2;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
   logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0]  out_idx_q, out_idx_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] pass_res [DEPTH];
   logic [DATA_W-1:0] cmp_a [NPAIR];
   logic [DATA_W-1:0] cmp_b [NPAIR];
   logic [DATA_W-1:0] cmp_lo [NPAIR];
   logic [DATA_W-1:0] cmp_hi [NPAIR];
   logic              phase;
   logic              accept;
   logic              sort_desc;
   logic              sort_mode;

   assign phase     = pass_cnt_q[0];
   assign sort_desc = (mode_q == MODE_DESC);
   assign sort_mode = (mode_q == MODE_DESC) || (mode_q == MODE_ASC);
   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign accept    = in_valid && in_ready;
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_OUT);
   assign out_index = out_idx_q;
   assign data_out  = out_valid ? mem_q[out_idx_q] : '0;

   // Even phase pairs (0,1),(2,3)..; odd phase pairs (1,2),(3,4)..
   for (genvar k = 0; k < NPAIR; k++) begin : g_pair
      assign cmp_a[k] = phase ? mem_q[2*k+1] : mem_q[2*k];
      if (2*k+2 < DEPTH) begin : g_b_odd
         assign cmp_b[k] = phase ? mem_q[2*k+2] : mem_q[2*k+1];
      end else begin : g_b_even
         assign cmp_b[k] = mem_q[2*k+1];
      end
      sort_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
         .a      (cmp_a[k]),
         .b      (cmp_b[k]),
         .dir    (sort_desc),
         .lo_pos (cmp_lo[k]),
         .hi_pos (cmp_hi[k])
      );
   end

   // Route each slot to whichever pair owns it this phase; unpaired slots hold.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [DATA_W-1:0] ev, od;
      if ((i % 2 == 0) && (i + 1 < DEPTH)) begin : g_ev_lo
         assign ev = cmp_lo[i/2];
      end else if (i % 2 == 1) begin : g_ev_hi
         assign ev = cmp_hi[i/2];
      end else begin : g_ev_keep
         assign ev = mem_q[i];
      end
      if ((i % 2 == 1) && (i + 1 < DEPTH)) begin : g_od_lo
         assign od = cmp_lo[i/2];
      end else if ((i % 2 == 0) && (i > 0)) begin : g_od_hi
         assign od = cmp_hi[i/2-1];
      end else begin : g_od_keep
         assign od = mem_q[i];
      end
      assign pass_res[i] = phase ? od : ev;
   end

   always_comb begin
      mem_d = mem_q;
      if (accept) begin
         mem_d[load_cnt_q] = data_in;
      end else if (state_q == ST_SORT) begin
         mem_d = pass_res;
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      load_cnt_d = load_cnt_q;
      pass_cnt_d = pass_cnt_q;
      out_idx_d  = out_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mode_d     = mode;
               load_cnt_d = CNT_W'(1);
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               if (load_cnt_q == LAST) begin
                  load_cnt_d = '0;
                  pass_cnt_d = '0;
                  state_d    = sort_mode ? ST_SORT : ST_OUT;
               end else begin
                  load_cnt_d = load_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_SORT: begin
            if (pass_cnt_q == LAST) begin
               pass_cnt_d = '0;
               state_d    = ST_OUT;
            end else begin
               pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               if (out_idx_q == LAST) begin
                  out_idx_d = '0;
                  state_d   = ST_IDLE;
               end else begin
                  out_idx_d = out_idx_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_PASS;
         load_cnt_q <= '0;
         pass_cnt_q <= '0;
         out_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         load_cnt_q <= load_cnt_d;
         pass_cnt_q <= pass_cnt_d;
         out_idx_q  <= out_idx_d;
      end
   end

   // Buffer is deliberately not reset; outputs are gated by state instead.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_sort_seq.sv
// tb/tb_sort_seq.sv - self-checking bench for sort_seq
module tb_sort_seq;

   localparam int DW = 9;
   localparam int DP = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    mode;
   logic [DW-1:0] data_in;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] data_out;
   logic [2:0]    out_index;
   logic          busy;

   int            n_pass = 0;
   int            n_total = 0;
   logic [DW-1:0] exp_q [$];

   typedef struct packed {
      logic [1:0]         m;
      logic [DP-1:0][8:0] w;
      logic [DP-1:0][8:0] e;
      int                 gap;
      int                 stall;
      bit                 toggle;
      bit                 stray;
   } vec_t;

   vec_t vecs [6];

   sort_seq #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_index (out_index),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [DP-1:0][8:0] pk(input int a0, a1, a2, a3, a4, a5);
      logic [DP-1:0][8:0] r;
      r[0] = a0[8:0]; r[1] = a1[8:0]; r[2] = a2[8:0];
      r[3] = a3[8:0]; r[4] = a4[8:0]; r[5] = a5[8:0];
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic send(input vec_t v);
      int waits;
      for (int i = 0; i < DP; i++) begin
         if (i == v.gap) begin
            in_valid = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         data_in  = v.w[i];
         mode     = (i > 0 && v.toggle) ? ~v.m : v.m;
         waits    = 0;
         while (!in_ready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
         end
         if (i == 0) chk("first_word_accept_wait", waits, 0);
         else if (waits >= 50) chk("accept_timeout", waits, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      for (int i = 0; i < DP; i++) exp_q.push_back(v.e[i]);
   endtask

   task automatic recv(input int exp_lat, input int stall, input bit stray);
      int lat = 0;
      int e;
      bit busy_ok = 1'b1;
      bit zero_ok = 1'b1;
      while (!out_valid && lat < 50) begin
         if (!busy) busy_ok = 1'b0;
         if (data_out != '0) zero_ok = 1'b0;
         if (stray) begin
            in_valid = 1'b1;
            data_in  = 9'h1AA;
         end
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      chk("first_out_latency", lat + 1, exp_lat);
      chk("busy_before_output", int'(busy_ok), 1);
      chk("data_zero_while_invalid", int'(zero_ok), 1);
      for (int i = 0; i < DP; i++) begin
         e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
         chk("out_valid", int'(out_valid), 1);
         chk("out_index", int'(out_index), i);
         chk("data_out", int'(data_out), e);
         if (i == stall) begin
            out_ready = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
               chk("stall_index_hold", int'(out_index), i);
               chk("stall_data_hold", int'(data_out), e);
            end
            out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk("idle_in_ready", int'(in_ready), 1);
      chk("idle_out_valid", int'(out_valid), 0);
      chk("idle_busy", int'(busy), 0);
   endtask

   function automatic int lat_for(input logic [1:0] m);
      return (m == 2'b01 || m == 2'b10) ? DP + 1 : 1;
   endfunction

   initial begin
      vecs[0] = '{m: 2'b00, w: pk(5, 300, 0, 511, 7, 7), e: pk(5, 300, 0, 511, 7, 7),
                  gap: -1, stall: -1, toggle: 1'b0, stray: 1'b0};
      vecs[1] = '{m: 2'b01, w: pk(3, 9, 1, 9, 0, 4), e: pk(9, 9, 4, 3, 1, 0),
                  gap: -1, stall: -1, toggle: 1'b0, stray: 1'b0};
      vecs[2] = '{m: 2'b10, w: pk(511, 0, 256, 0, 1, 2), e: pk(0, 0, 1, 2, 256, 511),
                  gap: -1, stall: 1, toggle: 1'b0, stray: 1'b0};
      vecs[3] = '{m: 2'b01, w: pk(10, 20, 30, 40, 50, 60), e: pk(60, 50, 40, 30, 20, 10),
                  gap: 3, stall: -1, toggle: 1'b1, stray: 1'b1};
      vecs[4] = '{m: 2'b11, w: pk(8, 1, 7, 2, 6, 3), e: pk(8, 1, 7, 2, 6, 3),
                  gap: -1, stall: -1, toggle: 1'b0, stray: 1'b0};
      vecs[5] = '{m: 2'b10, w: pk(6, 5, 4, 3, 2, 1), e: pk(1, 2, 3, 4, 5, 6),
                  gap: -1, stall: -1, toggle: 1'b0, stray: 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mode      = 2'b00;
      data_in   = '0;
      repeat (2) begin @(posedge clk); #1; end
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_data_out", int'(data_out), 0);
      chk("reset_out_index", int'(out_index), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int t = 0; t < 5; t++) begin
         send(vecs[t]);
         recv(lat_for(vecs[t].m), vecs[t].stall, vecs[t].stray);
      end

      send(vecs[1]);
      repeat (2) begin @(posedge clk); #1; end
      chk("sort_busy_before_abort", int'(busy), 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_data_out", int'(data_out), 0);
      chk("abort_in_ready", int'(in_ready), 1);
      chk("abort_busy", int'(busy), 0);
      chk("abort_out_index", int'(out_index), 0);
      exp_q.delete();

      send(vecs[5]);
      recv(lat_for(vecs[5].m), vecs[5].stall, vecs[5].stray);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
